// File: rtl/mem_pkg.sv
// Shared EX/MEM field offsets, FSM state encoding and write-back source select
// for the memory-access stage.
package mem_pkg;

  // EX/MEM offsets counted from bit N, i.e. just above the N-bit rd3 field.
  localparam int unsigned ExRcOff       = 0;
  localparam int unsigned ExRegWriteOff = 4;
  localparam int unsigned ExMemToRegOff = 5;
  localparam int unsigned ExMemWriteOff = 6;
  localparam int unsigned ExBranchOff   = 7;
  localparam int unsigned ExNegOff      = 8;
  localparam int unsigned ExZeroOff     = 9;
  localparam int unsigned ExAluOff      = 10;
  // EX/MEM offsets counted from bit 2*N.
  localparam int unsigned ExOpCodeOff   = 10;
  localparam int unsigned ExOpTypeOff   = 14;

  // MEM/WB offsets counted from bit 2*N.
  localparam int unsigned WbRegWriteOff = 4;
  localparam int unsigned WbMemToRegOff = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StHold   = 2'd2
  } mem_state_t;

  typedef enum logic [2:0] {
    WbFields = 3'd0,
    WbBubble = 3'd1,
    WbAck    = 3'd2,
    WbLat    = 3'd3,
    WbKill   = 3'd4
  } wb_src_t;

endpackage

// File: rtl/mem_ctrl_fsm.sv
// Memory-stage control: IDLE/ACCESS/HOLD sequencing, request/strobe registers, stall and
// write-back load strobe. Optional access timeout is enabled by MEM_TIMEOUT_EN.
module mem_ctrl_fsm import mem_pkg::*; #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mem_op,
  input  logic       mem_write,
  input  logic       mem_ack,
  output logic       stall,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_err,
  output logic       wb_load,
  output logic       lat_load,
  output logic [2:0] wb_src
);

  mem_state_t state_q, state_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic       timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic            err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == StAccess && !mem_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // cnt_q holds the number of ACCESS cycles already spent without an ack.
  assign timeout = (state_q == StAccess) && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (timeout && !mem_ack) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    stall    = 1'b0;
    wb_load  = 1'b0;
    lat_load = 1'b0;
    wb_src   = WbFields;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          wb_load = 1'b1;
          if (mem_op) begin
            stall   = 1'b1;
            wb_src  = WbBubble;
            state_d = StAccess;
            req_d   = 1'b1;
            we_d    = mem_write;
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (en) begin
            wb_load = 1'b1;
            wb_src  = WbAck;
            state_d = StIdle;
          end else begin
            lat_load = 1'b1;
            state_d  = StHold;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wb_load = 1'b1;
          wb_src  = WbKill;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (en) begin
            wb_load = 1'b1;
            wb_src  = WbBubble;
          end
        end
      end
      StHold: begin
        if (en) begin
          wb_load = 1'b1;
          wb_src  = WbLat;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rst) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  assign mem_req = req_q;
  assign mem_we  = we_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM decode, load/store handshake, branch resolve and
// MEM/WB register. Define MEM_TIMEOUT_EN to enable the access timeout and memErr.
module mem_stage import mem_pkg::*; #(
  parameter int unsigned N       = 24,
  parameter int unsigned BW      = 64,
  parameter int unsigned WBW     = 60,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [BW-1:0]  exBuffer,
  output logic [N-1:0]   memAddr,
  output logic [N-1:0]   memWdata,
  output logic           memReq,
  output logic           memWe,
  input  logic [N-1:0]   memRdata,
  input  logic           memAck,
  output logic           stall,
  output logic           pcSrc,
  output logic [N-1:0]   branchTarget,
  output logic           memErr,
  output logic [WBW-1:0] wbBuffer
);

  logic [1:0]     op_type;
  logic [3:0]     op_code;
  logic [N-1:0]   alu_result;
  logic           zero_flag;
  logic           branch_flag;
  logic           mem_write;
  logic           mem_to_reg;
  logic           reg_write;
  logic [3:0]     rc;
  logic [N-1:0]   rd3;
  logic           unused_neg;

  assign op_type     = exBuffer[2*N+ExOpTypeOff +: 2];
  assign op_code     = exBuffer[2*N+ExOpCodeOff +: 4];
  assign alu_result  = exBuffer[N+ExAluOff +: N];
  assign zero_flag   = exBuffer[N+ExZeroOff];
  assign unused_neg  = exBuffer[N+ExNegOff];
  assign branch_flag = exBuffer[N+ExBranchOff];
  assign mem_write   = exBuffer[N+ExMemWriteOff];
  assign mem_to_reg  = exBuffer[N+ExMemToRegOff];
  assign reg_write   = exBuffer[N+ExRegWriteOff];
  assign rc          = exBuffer[N+ExRcOff +: 4];
  assign rd3         = exBuffer[N-1:0];

  logic       wb_load;
  logic       lat_load;
  logic [2:0] wb_src;

  mem_ctrl_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mem_op   (mem_to_reg | mem_write),
    .mem_write(mem_write),
    .mem_ack  (memAck),
    .stall    (stall),
    .mem_req  (memReq),
    .mem_we   (memWe),
    .mem_err  (memErr),
    .wb_load  (wb_load),
    .lat_load (lat_load),
    .wb_src   (wb_src)
  );

  assign memAddr      = alu_result;
  assign memWdata     = rd3;
  assign branchTarget = alu_result;
  assign pcSrc        = rst & branch_flag & zero_flag & ~stall;

  // Stores complete with zero read data, so only loads capture memRdata.
  logic [N-1:0] lat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_q <= '0;
    end else if (lat_load) begin
      lat_q <= mem_to_reg ? memRdata : '0;
    end
  end

  logic [N-1:0]   read_data;
  logic           wb_mtr;
  logic           wb_rw;
  logic [WBW-1:0] wb_d, wb_q;

  always_comb begin
    read_data = '0;
    wb_mtr    = mem_to_reg;
    wb_rw     = reg_write;
    unique case (wb_src)
      WbAck:   read_data = mem_to_reg ? memRdata : '0;
      WbLat:   read_data = lat_q;
      WbKill: begin
        wb_mtr = 1'b0;
        wb_rw  = 1'b0;
      end
      default: ;
    endcase
    wb_d = {op_type, op_code, wb_mtr, wb_rw, rc, alu_result, read_data};
    if (wb_src == WbBubble) begin
      wb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (wb_load) begin
      wb_q <= wb_d;
    end
  end

  assign wbBuffer = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps plus randomized transactions
// checked against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [63:0] exBuffer = '0;
  logic [23:0] memAddr, memWdata, memRdata, branchTarget;
  logic        memReq, memWe, memAck, stall, pcSrc, memErr;
  logic [59:0] wbBuffer;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .N(24), .BW(64), .WBW(60), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .exBuffer(exBuffer),
    .memAddr(memAddr), .memWdata(memWdata), .memReq(memReq), .memWe(memWe),
    .memRdata(memRdata), .memAck(memAck), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .memErr(memErr), .wbBuffer(wbBuffer)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_ex(input logic [1:0] ot, input logic [3:0] oc,
                                        input logic [23:0] alu, input logic z, input logic br,
                                        input logic mw, input logic mtr, input logic rw,
                                        input logic [3:0] rc, input logic [23:0] rd3);
    logic [63:0] e;
    e = '0;
    e[63:62] = ot;  e[61:58] = oc;  e[57:34] = alu;
    e[33] = z;      e[32] = 1'b0;   e[31] = br;
    e[30] = mw;     e[29] = mtr;    e[28] = rw;
    e[27:24] = rc;  e[23:0] = rd3;
    return e;
  endfunction

  // Write-back word the stage should produce for a completed instruction.
  function automatic logic [59:0] model_wb(input logic [63:0] ex, input logic [23:0] rd,
                                           input logic kill);
    logic [59:0] w;
    w[59:58] = ex[63:62];
    w[57:54] = ex[61:58];
    w[53]    = ex[29] & ~kill;
    w[52]    = ex[28] & ~kill;
    w[51:48] = ex[27:24];
    w[47:24] = ex[57:34];
    w[23:0]  = rd;
    return w;
  endfunction

  // One instruction through the stage; ack in the k-th ACCESS cycle, and if hold > 0 the
  // ack arrives with en=0 and en stays low for hold further cycles.
  task automatic run_txn(input logic [63:0] ex, input int k, input int hold,
                         input logic [23:0] rdata);
    logic        is_mem;
    logic [59:0] exp_wb;
    int          stalls;
    is_mem = ex[29] | ex[30];
    exp_wb = model_wb(ex, ex[29] ? rdata : 24'h0, 1'b0);
    stalls = 0;
    @(negedge clk);
    exBuffer = ex; en = 1'b1; memAck = 1'b0; memRdata = 24'($urandom);
    #1;
    chk("addr", memAddr, ex[57:34]);
    chk("target", branchTarget, ex[57:34]);
    if (!is_mem) begin
      chk("stall_nomem", stall, 0);
      chk("pcsrc", pcSrc, ex[31] & ex[33]);
      @(posedge clk); #1;
      chk("wb_nomem", wbBuffer, exp_wb);
      return;
    end
    chk("stall_idle", stall, 1);
    chk("pcsrc_stalled", pcSrc, 0);
    if (stall) stalls++;
    @(posedge clk); #1;
    chk("wb_bubble", wbBuffer, 0);
    chk("req_rise", memReq, 1);
    chk("we", memWe, ex[30]);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      memAck = (i == k);
      memRdata = (i == k) ? rdata : 24'($urandom);
      en = (i == k && hold > 0) ? 1'b0 : 1'b1;
      #1;
      chk("req_access", memReq, 1);
      chk("wdata", memWdata, ex[23:0]);
      if (stall) stalls++;
      if (i == k) begin
        chk("stall_ack", stall, 0);
        chk("pcsrc_ack", pcSrc, ex[31] & ex[33]);
      end
      @(posedge clk); #1;
      if (i < k) chk("wb_stalled", wbBuffer, 0);
    end
    chk("req_fall", memReq, 0);
    if (hold == 0) begin
      chk("stall_count", stalls, k);
      chk("wb_mem", wbBuffer, exp_wb);
    end else begin
      chk("wb_ack_held", wbBuffer, 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        memAck = 1'b0; en = 1'b0; memRdata = 24'($urandom);
        #1;
        chk("stall_hold", stall, 1);
        @(posedge clk); #1;
        chk("wb_hold", wbBuffer, 0);
      end
      @(negedge clk);
      en = 1'b1;
      #1;
      chk("stall_release", stall, 0);
      @(posedge clk); #1;
      chk("wb_latched", wbBuffer, exp_wb);
    end
  endtask

  initial begin
    logic [63:0] ex;
    logic [63:0] prev;
    logic [59:0] wb_prev;
    int          kind;

    // Reset forces outputs low even with a pending branch/load on the input.
    memAck = 1'b1; memRdata = 24'hABCDEF; en = 1'b1;
    exBuffer = mk_ex(2'd1, 4'h1, 24'h20, 1, 1, 0, 1, 1, 4'h2, 24'h0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_wb", wbBuffer, 0);
    chk("rst_req", memReq, 0);
    chk("rst_we", memWe, 0);
    chk("rst_err", memErr, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pcsrc", pcSrc, 0);
    @(negedge clk);
    rst = 1'b1; memAck = 1'b0;
    exBuffer = mk_ex(2'd0, 4'h0, 24'h0, 0, 0, 0, 0, 0, 4'h0, 24'h0);

    // ADD
    ex = mk_ex(2'd0, 4'h3, 24'h4, 0, 0, 0, 0, 1, 4'h3, 24'h0);
    run_txn(ex, 1, 0, 24'h0);
    chk("add_alu", wbBuffer[47:24], 24'h4);
    chk("add_rc", wbBuffer[51:48], 4'h3);
    chk("add_rw", wbBuffer[52], 1);
    chk("add_rd", wbBuffer[23:0], 0);
    // Load acked in the 3rd ACCESS cycle
    ex = mk_ex(2'd1, 4'h8, 24'h000010, 0, 0, 0, 1, 1, 4'h5, 24'h0);
    run_txn(ex, 3, 0, 24'h00ABCD);
    chk("load_rd", wbBuffer[23:0], 24'h00ABCD);
    chk("load_mtr", wbBuffer[53], 1);
    // Store with immediate ack
    ex = mk_ex(2'd1, 4'h9, 24'h000044, 0, 0, 1, 0, 0, 4'h0, 24'h123456);
    run_txn(ex, 1, 0, 24'h777777);
    chk("store_rd", wbBuffer[23:0], 0);
    // Branch taken / not taken
    ex = mk_ex(2'd2, 4'h4, 24'h20, 1, 1, 0, 0, 0, 4'h0, 24'h0);
    run_txn(ex, 1, 0, 24'h0);
    ex = mk_ex(2'd2, 4'h4, 24'h20, 0, 1, 0, 0, 0, 4'h0, 24'h0);
    run_txn(ex, 1, 0, 24'h0);
    // Ack while en=0 goes through HOLD
    ex = mk_ex(2'd1, 4'h8, 24'h000030, 0, 0, 0, 1, 1, 4'h6, 24'h0);
    run_txn(ex, 2, 2, 24'h5A5A5A);

    // memAck outside ACCESS is ignored
    ex = mk_ex(2'd0, 4'h2, 24'h99, 0, 0, 0, 0, 1, 4'h1, 24'h0);
    @(negedge clk);
    exBuffer = ex; en = 1'b1; memAck = 1'b1; memRdata = 24'hFFFFFF;
    @(posedge clk); #1;
    chk("ack_idle_wb", wbBuffer, model_wb(ex, 24'h0, 1'b0));
    chk("ack_idle_req", memReq, 0);
    // en=0 in IDLE holds everything
    wb_prev = wbBuffer;
    @(negedge clk);
    memAck = 1'b0; en = 1'b0;
    exBuffer = mk_ex(2'd1, 4'h8, 24'h50, 0, 0, 0, 1, 1, 4'h2, 24'h0);
    @(posedge clk); #1;
    chk("en0_req", memReq, 0);
    chk("en0_wb", wbBuffer, wb_prev);

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      prev = {$urandom, $urandom};
      prev[32] = 1'b0;
      kind = $urandom_range(0, 2);
      prev[29] = (kind == 1);
      prev[30] = (kind == 2);
      run_txn(prev, $urandom_range(1, 4),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 24'($urandom));
    end

    // Reset in the middle of an access
    ex = mk_ex(2'd1, 4'h8, 24'h55, 0, 0, 0, 1, 1, 4'h4, 24'h0);
    @(negedge clk);
    exBuffer = ex; en = 1'b1; memAck = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_up", memReq, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", memReq, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_wb", wbBuffer, 0);
    @(negedge clk);
    rst = 1'b1;
    exBuffer = mk_ex(2'd0, 4'h1, 24'h11, 0, 0, 0, 0, 1, 4'h1, 24'h0);
    #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_req", memReq, 0);
    run_txn(mk_ex(2'd3, 4'h7, 24'h66, 0, 0, 0, 0, 1, 4'h8, 24'h0), 1, 0, 24'h0);

`ifdef MEM_TIMEOUT_EN
    ex = mk_ex(2'd1, 4'h2, 24'h40, 0, 0, 0, 1, 1, 4'h7, 24'h0);
    @(negedge clk);
    exBuffer = ex; en = 1'b1; memAck = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); #1;
      chk("to_stall", stall, (i < 15) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("to_err", memErr, 1);
    chk("to_req", memReq, 0);
    chk("to_wb", wbBuffer, model_wb(ex, 24'h0, 1'b1));
    chk("to_rw", wbBuffer[52], 0);
    run_txn(mk_ex(2'd0, 4'h1, 24'h3, 0, 0, 0, 0, 1, 4'h2, 24'h0), 1, 0, 24'h0);
    chk("to_sticky", memErr, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("to_rst_clear", memErr, 0);
    @(negedge clk);
    rst = 1'b1;
`else
    chk("err_tied", memErr, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
